// File: rtl/jedro_1_wb_arbiter.sv
// Round-robin writeback arbiter for the regfile write port, with a load-pending scoreboard.
// Optional macro JEDRO_1_WB_FORWARD_EN adds wpc-stage forwarding and an earlier scoreboard clear.
module jedro_1_wb_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_data_i,
  input  logic                      lsu_issue_i,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_issue_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rpa_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rpb_addr_i,
  output logic                      hazard_o,
  output logic [REG_ADDR_WIDTH-1:0] wpc_addr_o,
  output logic [DATA_WIDTH-1:0]     wpc_data_o,
  output logic                      wpc_we_o,
  output logic [DATA_WIDTH-1:0]     fwd_a_data_o,
  output logic                      fwd_a_hit_o,
  output logic [DATA_WIDTH-1:0]     fwd_b_data_o,
  output logic                      fwd_b_hit_o
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e grant_q, grant_d;

  logic                      accept;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      lsu_accept;

  logic [NUM_REGS-1:0] sb_q, sb_d;

  // Last-grant state register
  always_ff @(posedge clk_i) begin
    if (rst_i) grant_q <= GRANT_LSU;
    else       grant_q <= grant_d;
  end

  // Round-robin grant: on conflict the requester not granted last wins
  always_comb begin
    grant_d     = grant_q;
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      if (alu_valid_i && (!lsu_valid_i || grant_q == GRANT_LSU)) begin
        alu_ready_o = 1'b1;
        grant_d     = GRANT_ALU;
      end else if (lsu_valid_i) begin
        lsu_ready_o = 1'b1;
        grant_d     = GRANT_LSU;
      end
    end
  end

  assign accept     = alu_ready_o | lsu_ready_o;
  assign lsu_accept = lsu_valid_i & lsu_ready_o;
  assign sel_addr   = alu_ready_o ? alu_addr_i : lsu_addr_i;
  assign sel_data   = alu_ready_o ? alu_data_i : lsu_data_i;

  // Registered write stage; x0 slots are consumed without a write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wpc_we_o   <= 1'b0;
      wpc_addr_o <= '0;
      wpc_data_o <= '0;
    end else if (accept && sel_addr != '0) begin
      wpc_we_o   <= 1'b1;
      wpc_addr_o <= sel_addr;
      wpc_data_o <= sel_data;
    end else begin
      wpc_we_o   <= 1'b0;
    end
  end

`ifdef JEDRO_1_WB_FORWARD_EN
  // Scoreboard clears on LSU acceptance; forwarding covers the wpc stage
  always_comb begin
    sb_d = sb_q;
    if (lsu_accept) sb_d[lsu_addr_i] = 1'b0;
    if (lsu_issue_i) sb_d[lsu_issue_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign fwd_a_hit_o  = wpc_we_o && (wpc_addr_o == rpa_addr_i);
  assign fwd_b_hit_o  = wpc_we_o && (wpc_addr_o == rpb_addr_i);
  assign fwd_a_data_o = wpc_data_o;
  assign fwd_b_data_o = wpc_data_o;
`else
  logic                      clr_pend_q;
  logic [REG_ADDR_WIDTH-1:0] clr_addr_q;

  // Clear is deferred to the wpc cycle; a re-issue in the acceptance cycle cancels it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_pend_q <= lsu_accept && !(lsu_issue_i && lsu_issue_addr_i == lsu_addr_i);
      clr_addr_q <= lsu_addr_i;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (clr_pend_q) sb_d[clr_addr_q] = 1'b0;
    if (lsu_issue_i) sb_d[lsu_issue_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign fwd_a_hit_o  = 1'b0;
  assign fwd_b_hit_o  = 1'b0;
  assign fwd_a_data_o = '0;
  assign fwd_b_data_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign hazard_o = sb_q[rpa_addr_i] | sb_q[rpb_addr_i];

endmodule

// File: tb/tb_jedro_1_wb_arbiter.sv
// Directed bench for jedro_1_wb_arbiter: expected writes are queued at drive time
// and popped after each clock edge.
module tb_jedro_1_wb_arbiter;

`ifdef JEDRO_1_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_addr, lsu_addr, issue_addr, rpa, rpb, wpc_addr;
  logic [31:0] alu_data, lsu_data, wpc_data, fwd_a_data, fwd_b_data;
  logic        issue, hazard, wpc_we, fwd_a_hit, fwd_b_hit;

  typedef struct packed {
    logic        full;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic m_last   = 1'b1;  // 0 = ALU, 1 = LSU
  int   ai, li;

  always #5 clk = ~clk;

  jedro_1_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
    .lsu_issue_i(issue), .lsu_issue_addr_i(issue_addr),
    .rpa_addr_i(rpa), .rpb_addr_i(rpb), .hazard_o(hazard),
    .wpc_addr_o(wpc_addr), .wpc_data_o(wpc_data), .wpc_we_o(wpc_we),
    .fwd_a_data_o(fwd_a_data), .fwd_a_hit_o(fwd_a_hit),
    .fwd_b_data_o(fwd_b_data), .fwd_b_hit_o(fwd_b_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check readies/hazard, queue the expected write, clock, check wpc/forwarding
  task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iss, input logic [4:0] ia, input logic [4:0] ra,
                      input logic [4:0] rb, input logic exp_haz);
    logic ea, el, ha, hb;
    wr_t  e;
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    issue = iss; issue_addr = ia; rpa = ra; rpb = rb;
    #1;
    ea = !r && av && (!lv || m_last);
    el = !r && lv && !ea;
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    chk("lsu_ready", 32'(lsu_ready), 32'(el));
    if (!r) chk("hazard", 32'(hazard), 32'(exp_haz));
    if (r) begin
      exp_q.push_back('{1'b1, 1'b0, 5'd0, 32'd0});
      m_last = 1'b1;
    end else if (ea) begin
      exp_q.push_back('{1'b0, aa != 5'd0, aa, ad});
      m_last = 1'b0;
    end else if (el) begin
      exp_q.push_back('{1'b0, la != 5'd0, la, ld});
      m_last = 1'b1;
    end else begin
      exp_q.push_back('{1'b0, 1'b0, 5'd0, 32'd0});
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("wpc_we", 32'(wpc_we), 32'(e.we));
    if (e.we || e.full) begin
      chk("wpc_addr", 32'(wpc_addr), 32'(e.addr));
      chk("wpc_data", wpc_data, e.data);
    end
    ha = FWD && e.we && e.addr == ra;
    hb = FWD && e.we && e.addr == rb;
    chk("fwd_a_hit", 32'(fwd_a_hit), 32'(ha));
    chk("fwd_b_hit", 32'(fwd_b_hit), 32'(hb));
    if (ha) chk("fwd_a_data", fwd_a_data, e.data);
    if (hb) chk("fwd_b_data", fwd_b_data, e.data);
    if (!FWD) begin
      chk("fwd_a_data_zero", fwd_a_data, 32'd0);
      chk("fwd_b_data_zero", fwd_b_data, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1; issue = 1'b0;
    alu_addr = '0; lsu_addr = '0; alu_data = '0; lsu_data = '0;
    issue_addr = '0; rpa = '0; rpb = '0;

    // Reset held two cycles with both requesters valid
    step(1, 1, 5'd1, 32'hA000_0001, 1, 5'd9, 32'hB000_0009, 0, 0, 7, 0, 0);
    step(1, 1, 5'd1, 32'hA000_0001, 1, 5'd9, 32'hB000_0009, 0, 0, 7, 0, 0);
    chk("reset_hazard", 32'(hazard), 32'd0);

    // Single ALU write, then an idle cycle
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset right after an acceptance drops the in-flight write
    step(0, 1, 5'd6, 32'h0000_0066, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Conflict: ALU x1.. vs LSU x9.., each holds until accepted
    ai = 1; li = 9;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5'(ai), 32'hA000_0000 + 32'(ai), 1, 5'(li), 32'hB000_0000 + 32'(li),
           0, 0, 0, 0, 0);
      if (m_last) li++; else ai++;
    end
    chk("conflict_alu_progress", 32'(ai), 32'd3);
    chk("conflict_lsu_progress", 32'(li), 32'd11);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // LSU write to x0: accepted, no regfile write, scoreboard untouched
    step(0, 0, 0, 0, 1, 5'd0, 32'h0000_1234, 0, 0, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);

    // Scoreboard: issue x7, stall, clear on LSU writeback
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1);
    step(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 7, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, !FWD);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);

    // Issue and accept x7 together: set wins; an ALU write to x7 leaves it pending
    step(0, 0, 0, 0, 1, 5'd7, 32'h78, 1, 5'd7, 0, 7, 0);
    step(0, 1, 5'd7, 32'h99, 0, 0, 0, 0, 0, 0, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 1);
    step(0, 0, 0, 0, 1, 5'd7, 32'h79, 0, 0, 0, 7, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, !FWD);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

    // Forwarding of x3 from the wpc stage to read port B
    step(0, 1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
